cpu_phase_sequencer: RTL and testbench

Sequences the multi-cycle RISC-V core from the single 100 MHz clock using clock enables instead of divided clocks. An internal prescaler produces a step tick every DIV cycles. On each tick, a phase FSM advances IF -> ID -> EX -> (MEM) -> WB and emits one-cycle phase enables to the datapath. It also provides run/step/halt debug control and a memory request/acknowledge handshake for the MEM phase.

---
 rtl/cpu_seq_pkg.sv | 24 ++
 rtl/cpu_phase_sequencer_if.sv | 31 +++
 rtl/seq_prescaler.sv | 14 +
 rtl/cpu_phase_sequencer.sv | 58 +++++
 tb/tb_cpu_phase_sequencer.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg: state encodings, phase-enable bit indices and defaults for the phase sequencer
package cpu_seq_pkg;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5
  } state_e;
  localparam int PH_IF  = 0;
  localparam int PH_ID  = 1;
  localparam int PH_EX  = 2;
  localparam int PH_MEM = 3;
  localparam int PH_WB  = 4;
  localparam int DIV_DEFAULT = 100;
  function automatic logic [4:0] phase_onehot(input state_e s);
    return s == S_IF  ? 5'(1) << PH_IF  :
           s == S_ID  ? 5'(1) << PH_ID  :
           s == S_EX  ? 5'(1) << PH_EX  :
           s == S_MEM ? 5'(1) << PH_MEM :
           s == S_WB  ? 5'(1) << PH_WB  : 5'd0;
  endfunction
endpackage

// File: rtl/cpu_phase_sequencer_if.sv
// cpu_phase_sequencer_if: debug control, decoder/memory handshake and phase outputs (SEQ_PERF_CNT_EN adds retired_cnt_o)
interface cpu_phase_sequencer_if;
  import cpu_seq_pkg::*;
  logic       run_i;
  logic       step_i;
  logic       halt_i;
  logic       mem_op_i;
  logic       mem_ack_i;
  logic [4:0] phase_en_o;
  state_e     phase_o;
  logic       mem_req_o;
  logic       retire_o;
  logic       halted_o;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] retired_cnt_o;
`endif
  modport master (
    output run_i, step_i, halt_i, mem_op_i, mem_ack_i,
`ifdef SEQ_PERF_CNT_EN
    input retired_cnt_o,
`endif
    input phase_en_o, phase_o, mem_req_o, retire_o, halted_o
  );
  modport slave (
    input run_i, step_i, halt_i, mem_op_i, mem_ack_i,
`ifdef SEQ_PERF_CNT_EN
    output retired_cnt_o,
`endif
    output phase_en_o, phase_o, mem_req_o, retire_o, halted_o
  );
endinterface

// File: rtl/seq_prescaler.sv
// seq_prescaler: free-running 0..DIV-1 counter emitting a one-cycle clock-enable tick
module seq_prescaler #(
  parameter int DIV   = 100,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);
  logic [CNT_W-1:0] cnt_q;
  assign tick_o = cnt_q == CNT_W'(DIV - 1);
  // wrap on the tick so the tick period is exactly DIV cycles
  always_ff @(posedge clk) cnt_q <= (!rst_n || tick_o) ? '0 : cnt_q + CNT_W'(1);
endmodule

// File: rtl/cpu_phase_sequencer.sv
// cpu_phase_sequencer: IF/ID/EX/MEM/WB clock-enable sequencer with run/step/halt; SEQ_PERF_CNT_EN adds a retire counter
module cpu_phase_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int DIV   = DIV_DEFAULT,
  parameter int CNT_W = 16
) (
  input logic                  clk_100M,
  input logic                  rst_n,
  cpu_phase_sequencer_if.slave sif
);
  state_e     state_q, state_d;
  logic [4:0] phase_en_q;
  logic       mem_req_q, mem_done_q, retire_q, step_pend_q;
  logic       tick, leave_wb, ack;
  seq_prescaler #(.DIV(DIV), .CNT_W(CNT_W)) u_pre (.clk(clk_100M), .rst_n(rst_n), .tick_o(tick));
  assign leave_wb = tick && state_q == S_WB;
  assign ack      = state_q == S_MEM && mem_req_q && sif.mem_ack_i;
  // next phase; halt only gates the instruction boundaries (IDLE and WB exit)
  always_comb begin
    state_d = !tick                ? state_q :
              state_q == S_IDLE    ? (((sif.run_i || step_pend_q) && !sif.halt_i) ? S_IF : S_IDLE) :
              state_q == S_IF      ? S_ID :
              state_q == S_ID      ? S_EX :
              state_q == S_EX      ? (sif.mem_op_i ? S_MEM : S_WB) :
              state_q == S_MEM     ? (mem_done_q ? S_WB : S_MEM) :
              state_q == S_WB      ? ((sif.run_i && !sif.halt_i) ? S_IF : S_IDLE) : S_IDLE;
  end
  // phase FSM with registered enables; a held MEM phase does not re-pulse its enable
  always_ff @(posedge clk_100M) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      phase_en_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      retire_q    <= 1'b0;
      step_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_en_q  <= state_d != state_q ? phase_onehot(state_d) : '0;
      mem_req_q   <= (state_d == S_MEM && state_q != S_MEM) ? 1'b1 : ack ? 1'b0 : mem_req_q;
      mem_done_q  <= (state_q == S_MEM && state_d != S_MEM) ? 1'b0 : ack ? 1'b1 : mem_done_q;
      retire_q    <= leave_wb;
      step_pend_q <= sif.step_i || (step_pend_q && !leave_wb);
    end
  end
  assign sif.phase_en_o = phase_en_q;
  assign sif.phase_o    = state_q;
  assign sif.mem_req_o  = mem_req_q;
  assign sif.retire_o   = retire_q;
  assign sif.halted_o   = state_q == S_IDLE;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] perf_cnt_q;
  // counts retires alongside the retire pulse, wrapping naturally at 2^32
  always_ff @(posedge clk_100M) perf_cnt_q <= !rst_n ? '0 : perf_cnt_q + {31'd0, leave_wb};
  assign sif.retired_cnt_o = perf_cnt_q;
`endif
endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// tb_cpu_phase_sequencer: directed checks of the phase sequencer with DIV=4
module tb_cpu_phase_sequencer;
  import cpu_seq_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  cpu_phase_sequencer_if sif();
  cpu_phase_sequencer #(.DIV(4), .CNT_W(3)) dut (.clk_100M(clk), .rst_n(rst_n), .sif(sif));

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic run, input logic mem_op);
    rst_n = 1'b0;
    sif.run_i = 1'b0;
    sif.step_i = 1'b0;
    sif.halt_i = 1'b0;
    sif.mem_op_i = 1'b0;
    sif.mem_ack_i = 1'b0;
    cyc;
    cyc;
    sif.run_i = run;
    sif.mem_op_i = mem_op;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset(1'b0, 1'b0);
    rst_n = 1'b0;
    cyc;
    checks += 6;
    if (sif.phase_en_o !== 5'd0) begin errors++; $display("FAIL reset_phase_en got %b exp 00000", sif.phase_en_o); end
    if (sif.phase_o !== S_IDLE) begin errors++; $display("FAIL reset_phase got %0d exp 0", sif.phase_o); end
    if (sif.mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b exp 0", sif.mem_req_o); end
    if (sif.retire_o !== 1'b0) begin errors++; $display("FAIL reset_retire got %b exp 0", sif.retire_o); end
    if (sif.halted_o !== 1'b1) begin errors++; $display("FAIL reset_halted got %b exp 1", sif.halted_o); end
    if (dut.u_pre.cnt_q !== 3'd0) begin errors++; $display("FAIL reset_prescaler got %0d exp 0", dut.u_pre.cnt_q); end
  endtask

  task automatic test_run;
    logic [4:0] seq [4] = '{5'd1, 5'd2, 5'd4, 5'd16};
    logic [4:0] epe;
    do_reset(1'b1, 1'b0);
    for (int c = 1; c <= 40; c++) begin
      cyc;
      epe = (c >= 4 && c % 4 == 0) ? seq[(c / 4 - 1) % 4] : 5'd0;
      checks += 3;
      if (sif.phase_en_o !== epe) begin errors++; $display("FAIL run_phase_en c=%0d got %b exp %b", c, sif.phase_en_o, epe); end
      if (sif.retire_o !== (c >= 20 && (c - 4) % 16 == 0)) begin errors++; $display("FAIL run_retire c=%0d got %b", c, sif.retire_o); end
      if (sif.halted_o !== (c < 4)) begin errors++; $display("FAIL run_halted c=%0d got %b", c, sif.halted_o); end
    end
  endtask

  task automatic test_mem;
    logic [4:0] epe;
    do_reset(1'b1, 1'b1);
    for (int c = 1; c <= 33; c++) begin
      sif.mem_ack_i = (c == 6 || c == 25);
      cyc;
      epe = (c == 4 || c == 32) ? 5'd1 : c == 8 ? 5'd2 : c == 12 ? 5'd4 : c == 16 ? 5'd8 : c == 28 ? 5'd16 : 5'd0;
      checks += 3;
      if (sif.phase_en_o !== epe) begin errors++; $display("FAIL mem_phase_en c=%0d got %b exp %b", c, sif.phase_en_o, epe); end
      if (sif.mem_req_o !== (c >= 16 && c <= 24)) begin errors++; $display("FAIL mem_req c=%0d got %b", c, sif.mem_req_o); end
      if (sif.retire_o !== (c == 32)) begin errors++; $display("FAIL mem_retire c=%0d got %b", c, sif.retire_o); end
      if (c == 26) begin
        checks++;
        if (sif.phase_o !== S_MEM) begin errors++; $display("FAIL mem_hold c=%0d got %0d exp 4", c, sif.phase_o); end
      end
    end
    sif.mem_ack_i = 1'b0;
  endtask

  // s=0: two merged steps; s=1: halt raised in EX while running; s=2: step with run, then run dropped
  task automatic test_single_instr;
    logic [4:0] epe;
    for (int s = 0; s < 3; s++) begin
      do_reset(1'b0, 1'b0);
      for (int c = 1; c <= 32; c++) begin
        sif.run_i = s == 1 || (s == 2 && c < 10);
        sif.step_i = s == 0 ? (c == 2 || c == 3) : (s == 2 && c == 1);
        sif.halt_i = s == 1 && c >= 13;
        cyc;
        epe = c == 4 ? 5'd1 : c == 8 ? 5'd2 : c == 12 ? 5'd4 : c == 16 ? 5'd16 : 5'd0;
        checks += 3;
        if (sif.phase_en_o !== epe) begin errors++; $display("FAIL single%0d_phase_en c=%0d got %b exp %b", s, c, sif.phase_en_o, epe); end
        if (sif.retire_o !== (c == 20)) begin errors++; $display("FAIL single%0d_retire c=%0d got %b", s, c, sif.retire_o); end
        if (sif.halted_o !== (c < 4 || c >= 20)) begin errors++; $display("FAIL single%0d_halted c=%0d got %b", s, c, sif.halted_o); end
      end
    end
    sif.halt_i = 1'b0;
    sif.step_i = 1'b0;
  endtask

  task automatic test_reset_mem;
    do_reset(1'b1, 1'b1);
    for (int c = 1; c <= 26; c++) begin
      rst_n = !(c == 18);
      cyc;
      checks++;
      if (sif.retire_o !== 1'b0) begin errors++; $display("FAIL rstmem_retire c=%0d got %b exp 0", c, sif.retire_o); end
      if (c == 17) begin
        checks += 2;
        if (sif.mem_req_o !== 1'b1) begin errors++; $display("FAIL rstmem_req_before got %b exp 1", sif.mem_req_o); end
        if (sif.phase_o !== S_MEM) begin errors++; $display("FAIL rstmem_phase_before got %0d exp 4", sif.phase_o); end
      end
      if (c == 18) begin
        checks += 5;
        if (sif.mem_req_o !== 1'b0) begin errors++; $display("FAIL rstmem_req got %b exp 0", sif.mem_req_o); end
        if (sif.phase_o !== S_IDLE) begin errors++; $display("FAIL rstmem_phase got %0d exp 0", sif.phase_o); end
        if (dut.u_pre.cnt_q !== 3'd0) begin errors++; $display("FAIL rstmem_prescaler got %0d exp 0", dut.u_pre.cnt_q); end
        if (sif.halted_o !== 1'b1) begin errors++; $display("FAIL rstmem_halted got %b exp 1", sif.halted_o); end
        if (sif.phase_en_o !== 5'd0) begin errors++; $display("FAIL rstmem_phase_en got %b exp 00000", sif.phase_en_o); end
      end
      if (c == 22) begin
        checks++;
        if (sif.phase_en_o !== 5'd1) begin errors++; $display("FAIL rstmem_restart got %b exp 00001", sif.phase_en_o); end
      end
    end
  endtask

`ifdef SEQ_PERF_CNT_EN
  task automatic test_perf;
    do_reset(1'b1, 1'b0);
    for (int c = 1; c <= 68; c++) begin
      cyc;
      if (c == 52) begin
        checks++;
        if (sif.retired_cnt_o !== 32'd3) begin errors++; $display("FAIL perf_three got %0d exp 3", sif.retired_cnt_o); end
      end
      if (c == 53) force dut.perf_cnt_q = 32'hFFFF_FFFF;
      if (c == 54) release dut.perf_cnt_q;
      if (c == 67) begin
        checks++;
        if (sif.retired_cnt_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL perf_forced got %h exp ffffffff", sif.retired_cnt_o); end
      end
      if (c == 68) begin
        checks++;
        if (sif.retired_cnt_o !== 32'd0) begin errors++; $display("FAIL perf_wrap got %h exp 0", sif.retired_cnt_o); end
      end
    end
  endtask
`endif

  initial begin
    test_reset;
    test_run;
    test_mem;
    test_single_instr;
    test_reset_mem;
`ifdef SEQ_PERF_CNT_EN
    test_perf;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
